// File: rtl/phys_reg_free_list_pkg.sv
// rtl/phys_reg_free_list_pkg.sv - shared rename/ROB constants and PR address type
package phys_reg_free_list_pkg;

  localparam int PR_ADDR_W  = 5;
  localparam int NUM_PR     = 32;
  localparam int NUM_ARCH   = 8;
  localparam int ALLOC_W    = 4;
  localparam int FREE_W     = 6;

  localparam int ALLOC_CT_W = $clog2(ALLOC_W) + 1;
  localparam int COUNT_W    = $clog2(NUM_PR + 1);
  localparam int NF_W       = $clog2(FREE_W + 1);

  typedef logic [PR_ADDR_W-1:0] pr_addr_t;

endpackage

// File: rtl/phys_reg_free_list_free_compact.sv
// rtl/phys_reg_free_list_free_compact.sv - packs valid freed PR slots into a dense list
module free_compact
  import phys_reg_free_list_pkg::*;
(
  input  logic [FREE_W*PR_ADDR_W-1:0] free_regs,
  input  logic [FREE_W-1:0]           free_valid,
  output logic [FREE_W*PR_ADDR_W-1:0] packed_regs,
  output logic [NF_W-1:0]             nf
);

  // Prefix-count over the mask: each valid slot lands at the number of valid slots below it
  always_comb begin
    logic [NF_W-1:0] w_pos;
    packed_regs = '0;
    w_pos       = '0;
    for (int i = 0; i < FREE_W; i++) begin
      if (free_valid[i]) begin
        packed_regs[int'(w_pos)*PR_ADDR_W +: PR_ADDR_W] = free_regs[i*PR_ADDR_W +: PR_ADDR_W];
        w_pos = w_pos + NF_W'(1);
      end
    end
    nf = w_pos;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular FIFO of free physical registers for rename
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  input  logic [ALLOC_CT_W-1:0]         alloc_ct,
  output logic                          alloc_ready,
  output logic [ALLOC_W*PR_ADDR_W-1:0]  alloc_regs,
  input  logic [FREE_W*PR_ADDR_W-1:0]   free_regs,
  input  logic [FREE_W-1:0]             free_valid,
  output logic [COUNT_W-1:0]            free_count,
  output logic                          overflow_err
);

  pr_addr_t             r_entry [NUM_PR];
  pr_addr_t             r_head;
  pr_addr_t             r_tail;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_overflow;

  logic [FREE_W*PR_ADDR_W-1:0] w_packed;
  logic [NF_W-1:0]             w_nf;
  logic                        w_grant;
  logic [COUNT_W-1:0]          w_granted;
  logic [COUNT_W-1:0]          w_after_alloc;
  logic [COUNT_W-1:0]          w_space;
  logic [COUNT_W-1:0]          w_nf_ext;
  logic [COUNT_W-1:0]          w_nf_acc;
  logic                        w_drop;

  free_compact u_free_compact (
    .free_regs   (free_regs),
    .free_valid  (free_valid),
    .packed_regs (w_packed),
    .nf          (w_nf)
  );

  // Readiness looks only at registered occupancy; same-cycle frees never help a request
  assign alloc_ready   = (COUNT_W'(alloc_ct) <= r_count);
  assign w_grant       = alloc_valid && alloc_ready;
  assign w_granted     = w_grant ? COUNT_W'(alloc_ct) : '0;
  assign w_after_alloc = r_count - w_granted;
  assign w_space       = COUNT_W'(NUM_PR) - w_after_alloc;
  assign w_nf_ext      = COUNT_W'(w_nf);
  assign w_drop        = (w_nf_ext > w_space);
  assign w_nf_acc      = w_drop ? w_space : w_nf_ext;

  // Lookahead window at head; slots beyond the current occupancy read as zero
  always_comb begin
    alloc_regs = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (COUNT_W'(k) < r_count) begin
        alloc_regs[k*PR_ADDR_W +: PR_ADDR_W] = r_entry[r_head + PR_ADDR_W'(k)];
      end
    end
  end

  // Pool state: head advances on grant, accepted frees append at tail, overflow is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PR; i++) begin
        r_entry[i] <= (i < NUM_PR - NUM_ARCH) ? PR_ADDR_W'(NUM_ARCH + i) : '0;
      end
      r_head     <= '0;
      r_tail     <= PR_ADDR_W'(NUM_PR - NUM_ARCH);
      r_count    <= COUNT_W'(NUM_PR - NUM_ARCH);
      r_overflow <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_W; j++) begin
        if (COUNT_W'(j) < w_nf_acc) begin
          r_entry[r_tail + PR_ADDR_W'(j)] <= w_packed[j*PR_ADDR_W +: PR_ADDR_W];
        end
      end
      r_head  <= r_head + PR_ADDR_W'(w_granted);
      r_tail  <= r_tail + PR_ADDR_W'(w_nf_acc);
      r_count <= w_after_alloc + w_nf_acc;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign free_count   = r_count;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - directed and model-checked bench for phys_reg_free_list
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         alloc_valid;
  logic [ALLOC_CT_W-1:0]        alloc_ct;
  logic                         alloc_ready;
  logic [ALLOC_W*PR_ADDR_W-1:0] alloc_regs;
  logic [FREE_W*PR_ADDR_W-1:0]  free_regs;
  logic [FREE_W-1:0]            free_valid;
  logic [COUNT_W-1:0]           free_count;
  logic                         overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  phys_reg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ct     (alloc_ct),
    .alloc_ready  (alloc_ready),
    .alloc_regs   (alloc_regs),
    .free_regs    (free_regs),
    .free_valid   (free_valid),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic int slot_of(input logic [ALLOC_W*PR_ADDR_W-1:0] v, input int k);
    return int'(v[k*PR_ADDR_W +: PR_ADDR_W]);
  endfunction

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    alloc_ct    = '0;
    free_valid  = '0;
    free_regs   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int exp[4] = '{8, 9, 10, 11};
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    alloc_ct = 3'd4;
    #1;
    n_tests++;
    if (free_count !== 6'd24) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 24", free_count);
    end
    n_tests++;
    if (overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overflow: got %0b want 0", overflow_err);
    end
    n_tests++;
    if (alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_ct4: got %0b want 1", alloc_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (slot_of(alloc_regs, k) !== exp[k]) begin
        n_fail++;
        $display("FAIL reset_regs slot%0d: got %0d want %0d", k, slot_of(alloc_regs, k), exp[k]);
      end
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 6; c++) begin
      alloc_valid = 1'b1;
      alloc_ct    = 3'd4;
      #1;
      n_tests++;
      if (alloc_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_ready c%0d: got %0b want 1", c, alloc_ready);
      end
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (slot_of(alloc_regs, k) !== 8 + 4*c + k) begin
          n_fail++;
          $display("FAIL drain_regs c%0d slot%0d: got %0d want %0d", c, k, slot_of(alloc_regs, k), 8 + 4*c + k);
        end
      end
      step();
    end
    alloc_valid = 1'b0;
    alloc_ct    = 3'd1;
    #1;
    n_tests++;
    if (free_count !== 6'd0) begin
      n_fail++;
      $display("FAIL drain_count: got %0d want 0", free_count);
    end
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_ready_ct1: got %0b want 0", alloc_ready);
    end
    alloc_ct = 3'd0;
    #1;
    n_tests++;
    if (alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_ready_ct0: got %0b want 1", alloc_ready);
    end
    n_tests++;
    if (alloc_regs !== '0) begin
      n_fail++;
      $display("FAIL empty_regs: got %h want 0", alloc_regs);
    end
  endtask

  task automatic test_free_from_empty();
    int exp[4] = '{3, 5, 7, 0};
    free_regs  = {5'd31, 5'd7, 5'd31, 5'd5, 5'd31, 5'd3};
    free_regs[4*PR_ADDR_W +: PR_ADDR_W] = 5'd30;
    free_regs[5*PR_ADDR_W +: PR_ADDR_W] = 5'd7;
    free_regs[1*PR_ADDR_W +: PR_ADDR_W] = 5'd29;
    free_regs[2*PR_ADDR_W +: PR_ADDR_W] = 5'd28;
    free_regs[3*PR_ADDR_W +: PR_ADDR_W] = 5'd5;
    free_regs[0*PR_ADDR_W +: PR_ADDR_W] = 5'd3;
    free_valid  = 6'b101001;
    alloc_valid = 1'b1;
    alloc_ct    = 3'd1;
    #1;
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL free_same_cycle_ready: got %0b want 0", alloc_ready);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (free_count !== 6'd3) begin
      n_fail++;
      $display("FAIL free_count: got %0d want 3", free_count);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (slot_of(alloc_regs, k) !== exp[k]) begin
        n_fail++;
        $display("FAIL free_regs slot%0d: got %0d want %0d", k, slot_of(alloc_regs, k), exp[k]);
      end
    end
  endtask

  task automatic test_refuse_with_free();
    int exp[4] = '{3, 5, 7, 20};
    free_regs   = '0;
    free_regs[1*PR_ADDR_W +: PR_ADDR_W] = 5'd20;
    free_regs[2*PR_ADDR_W +: PR_ADDR_W] = 5'd21;
    free_valid  = 6'b000110;
    alloc_valid = 1'b1;
    alloc_ct    = 3'd4;
    #1;
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL refuse_ready: got %0b want 0", alloc_ready);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (free_count !== 6'd5) begin
      n_fail++;
      $display("FAIL refuse_count: got %0d want 5", free_count);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (slot_of(alloc_regs, k) !== exp[k]) begin
        n_fail++;
        $display("FAIL refuse_regs slot%0d: got %0d want %0d", k, slot_of(alloc_regs, k), exp[k]);
      end
    end
  endtask

  task automatic test_random();
    int pool[$];
    int outstanding[$];
    int freed[$];
    int ct;
    int idx;
    int exp;
    bit vld;
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    for (int i = 8; i < 32; i++) pool.push_back(i);
    for (int cyc = 0; cyc < 200; cyc++) begin
      ct  = $urandom_range(0, 4);
      vld = ($urandom_range(0, 3) != 0);
      freed.delete();
      free_valid = '0;
      for (int s = 0; s < FREE_W; s++) begin
        if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
          idx = $urandom_range(0, outstanding.size() - 1);
          free_regs[s*PR_ADDR_W +: PR_ADDR_W] = PR_ADDR_W'(outstanding[idx]);
          freed.push_back(outstanding[idx]);
          outstanding.delete(idx);
          free_valid[s] = 1'b1;
        end else begin
          free_regs[s*PR_ADDR_W +: PR_ADDR_W] = PR_ADDR_W'($urandom_range(0, 31));
        end
      end
      alloc_valid = vld;
      alloc_ct    = ALLOC_CT_W'(ct);
      #1;
      n_tests++;
      if (alloc_ready !== (ct <= pool.size())) begin
        n_fail++;
        $display("FAIL rand_ready cyc%0d: got %0b want %0b", cyc, alloc_ready, ct <= pool.size());
      end
      n_tests++;
      if (int'(free_count) !== pool.size() || free_count > 6'd32) begin
        n_fail++;
        $display("FAIL rand_count cyc%0d: got %0d want %0d", cyc, free_count, pool.size());
      end
      for (int k = 0; k < 4; k++) begin
        exp = (k < pool.size()) ? pool[k] : 0;
        n_tests++;
        if (slot_of(alloc_regs, k) !== exp) begin
          n_fail++;
          $display("FAIL rand_regs cyc%0d slot%0d: got %0d want %0d", cyc, k, slot_of(alloc_regs, k), exp);
        end
      end
      if (vld && ct <= pool.size()) begin
        for (int g = 0; g < ct; g++) outstanding.push_back(pool.pop_front());
      end
      foreach (freed[f]) pool.push_back(freed[f]);
      step();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (int'(free_count) !== pool.size() || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_final: count %0d ovf %0b want count %0d ovf 0", free_count, overflow_err, pool.size());
    end
  endtask

  task automatic test_overflow();
    int exp[4] = '{8, 9, 10, 11};
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    for (int s = 0; s < FREE_W; s++) free_regs[s*PR_ADDR_W +: PR_ADDR_W] = PR_ADDR_W'(s);
    free_valid = 6'b111111;
    step();
    free_regs  = '0;
    free_regs[0 +: PR_ADDR_W] = 5'd6;
    free_valid = 6'b000001;
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (free_count !== 6'd31 || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_setup: count %0d ovf %0b want count 31 ovf 0", free_count, overflow_err);
    end
    free_regs[0*PR_ADDR_W +: PR_ADDR_W] = 5'd30;
    free_regs[1*PR_ADDR_W +: PR_ADDR_W] = 5'd31;
    free_valid = 6'b000011;
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (free_count !== 6'd32) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d want 32", free_count);
    end
    n_tests++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got %0b want 1", overflow_err);
    end
    step();
    n_tests++;
    if (overflow_err !== 1'b1 || free_count !== 6'd32) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf %0b count %0d want ovf 1 count 32", overflow_err, free_count);
    end
    rst         = 1'b1;
    alloc_valid = 1'b1;
    alloc_ct    = 3'd4;
    free_valid  = 6'b000011;
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_tests++;
    if (free_count !== 6'd24 || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_restore: count %0d ovf %0b want count 24 ovf 0", free_count, overflow_err);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (slot_of(alloc_regs, k) !== exp[k]) begin
        n_fail++;
        $display("FAIL rst_regs slot%0d: got %0d want %0d", k, slot_of(alloc_regs, k), exp[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_drain();
    test_free_from_empty();
    test_refuse_with_free();
    test_random();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
